pool_flatten_engine: RTL and testbench

- Parametrised successor to the fixed two-kernel max-pool/flatten stage of the CONV pipeline.
- Reads CH layer-0 feature maps of IMG_W x IMG_W words from the shared layer memories over the crd/cwr/csel bus.
- Applies 2x2, stride-2 pooling, either max or average (new mode).
- Writes the per-channel layer-1 maps and, when enabled, the channel-interleaved layer-2 flatten vector.

---
 rtl/pool_flatten_engine_if.sv | 25 ++
 rtl/pool_flatten_engine.sv | 151 +++++++++++++++
 tb/tb_pool_flatten_engine.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pool_flatten_engine_if.sv
// Layer-memory bus shared by the pooling engine (master) and the memory array (slave).
// Reads return data on the rising edge after the crd cycle; writes land on the rising edge.
interface pool_flatten_engine_if #(
    parameter int DW     = 20,
    parameter int ADDR_W = 12,
    parameter int CSEL_W = 3
);
    logic              crd;
    logic [ADDR_W-1:0] caddr_rd;
    logic [DW-1:0]     cdata_rd;
    logic              cwr;
    logic [ADDR_W-1:0] caddr_wr;
    logic [DW-1:0]     cdata_wr;
    logic [CSEL_W-1:0] csel;

    modport master (
        output crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel,
        input  cdata_rd
    );

    modport slave (
        input  crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel,
        output cdata_rd
    );
endinterface

// File: rtl/pool_flatten_engine.sv
// 2x2 stride-2 max/average pooling over CH layer-0 maps, writing layer-1 maps and an
// optional channel-interleaved flatten vector through a single read/write memory bus.
module pool_flatten_engine #(
    parameter int DW     = 20,
    parameter int IMG_W  = 64,
    parameter int CH     = 2,
    parameter int ADDR_W = 12,
    parameter int CSEL_W = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic ready,
    input  logic pool_mode,
    input  logic flat_en,
    output logic busy,
    pool_flatten_engine_if.master bus
);
    localparam int HALF = IMG_W / 2;
    localparam int NPIX = HALF * HALF;
    localparam int PW   = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int CW   = (CH > 1) ? $clog2(CH) : 1;
    localparam int LW   = $clog2(IMG_W);
    localparam int AW   = DW + 2;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_ACC   = 3'd2;
    localparam logic [2:0] S_WR_L1 = 3'd3;
    localparam logic [2:0] S_WR_FL = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]           state;
    logic [1:0]           k;
    logic [PW-1:0]        p;
    logic [CW-1:0]        c;
    logic                 avg_mode;
    logic                 flat_mode;
    logic signed [AW-1:0] acc;
    logic [DW-1:0]        result;

    logic                 capture;
    logic                 first_word;
    logic                 last_pc;
    logic signed [AW-1:0] word_x;
    logic signed [AW-1:0] acc_next;
    logic [ADDR_W-1:0]    base_addr;

    // Word k arrives one cycle after its READ cycle, so captures lag the reads by one state.
    assign capture    = (state == S_READ && k != 2'd0) || state == S_ACC;
    assign first_word = (state == S_READ && k == 2'd1);
    assign last_pc    = (p == PW'(NPIX - 1)) && (c == CW'(CH - 1));
    assign word_x     = {{2{bus.cdata_rd[DW-1]}}, bus.cdata_rd};
    assign base_addr  = (ADDR_W'(p >> (LW - 1)) << (LW + 1)) + (ADDR_W'(int'(p) % HALF) << 1);
    assign busy       = (state != S_IDLE);

    // The two guard bits keep a four-word sum of -2^(DW-1) values from overflowing.
    always_comb begin
        if (first_word)
            acc_next = word_x;
        else if (avg_mode)
            acc_next = acc + word_x;
        else
            acc_next = (word_x > acc) ? word_x : acc;
    end

    // NOTE: every output gets a default before the case so no latch is inferred and the
    // bus is all-zero whenever neither strobe is active.
    always_comb begin
        bus.crd      = 1'b0;
        bus.cwr      = 1'b0;
        bus.csel     = '0;
        bus.caddr_rd = '0;
        bus.caddr_wr = '0;
        bus.cdata_wr = '0;
        case (state)
            S_READ: begin
                bus.crd      = 1'b1;
                bus.csel     = CSEL_W'(1 + int'(c));
                bus.caddr_rd = base_addr + ADDR_W'(k[0]) + (k[1] ? ADDR_W'(IMG_W) : '0);
            end
            S_WR_L1: begin
                bus.cwr      = 1'b1;
                bus.csel     = CSEL_W'(1 + CH + int'(c));
                bus.caddr_wr = ADDR_W'(p);
                bus.cdata_wr = result;
            end
            S_WR_FL: begin
                bus.cwr      = 1'b1;
                bus.csel     = CSEL_W'(1 + 2 * CH);
                bus.caddr_wr = ADDR_W'(int'(p) * CH + int'(c));
                bus.cdata_wr = result;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values of the others.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            k         <= '0;
            p         <= '0;
            c         <= '0;
            avg_mode  <= 1'b0;
            flat_mode <= 1'b0;
            acc       <= '0;
            result    <= '0;
        end else begin
            if (capture)
                acc <= acc_next;
            case (state)
                S_IDLE: begin
                    if (ready) begin
                        avg_mode  <= pool_mode;
                        flat_mode <= flat_en;
                        p         <= '0;
                        c         <= '0;
                        k         <= '0;
                        state     <= S_READ;
                    end
                end
                S_READ: begin
                    k <= k + 2'd1;
                    if (k == 2'd3)
                        state <= S_ACC;
                end
                S_ACC: begin
                    // Upper DW bits of the sum are the arithmetic shift right by 2.
                    result <= avg_mode ? acc_next[DW+1:2] : acc_next[DW-1:0];
                    state  <= S_WR_L1;
                end
                S_WR_L1, S_WR_FL: begin
                    if (state == S_WR_L1 && flat_mode) begin
                        state <= S_WR_FL;
                    end else begin
                        state <= last_pc ? S_DONE : S_READ;
                        if (c == CW'(CH - 1)) begin
                            c <= '0;
                            p <= p + PW'(1);
                        end else begin
                            c <= c + CW'(1);
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pool_flatten_engine.sv
// Directed bench: default 64x64x2 engine plus an 8x8x4 instance, each with a behavioural
// layer memory; expected values are hand-derived or come from a per-window reference.
module tb_pool_flatten_engine;
    localparam int DW = 20, IMG_W = 64, CH = 2, AW = 12, SW = 3, NPIX = 1024;
    localparam int IMG_S = 8, CH_S = 4, AW_S = 6, SW_S = 4, NPIX_S = 16;

    logic clk = 1'b0, rst_n = 1'b0;
    logic ready = 1'b0, pool_mode = 1'b0, flat_en = 1'b0, busy;
    logic ready_s = 1'b0, mode_s = 1'b0, flat_s = 1'b0, busy_s;
    int   total = 0, bad = 0;

    always #5 clk = ~clk;

    pool_flatten_engine_if #(.DW(DW), .ADDR_W(AW), .CSEL_W(SW)) bus ();
    pool_flatten_engine_if #(.DW(DW), .ADDR_W(AW_S), .CSEL_W(SW_S)) bus_s ();

    pool_flatten_engine #(.DW(DW), .IMG_W(IMG_W), .CH(CH), .ADDR_W(AW), .CSEL_W(SW)) dut (
        .clk(clk), .reset(rst_n), .ready(ready), .pool_mode(pool_mode),
        .flat_en(flat_en), .busy(busy), .bus(bus));

    pool_flatten_engine #(.DW(DW), .IMG_W(IMG_S), .CH(CH_S), .ADDR_W(AW_S), .CSEL_W(SW_S)) dut_s (
        .clk(clk), .reset(rst_n), .ready(ready_s), .pool_mode(mode_s),
        .flat_en(flat_s), .busy(busy_s), .bus(bus_s));

    logic [DW-1:0] mem0 [CH][IMG_W*IMG_W];
    logic [DW-1:0] l1 [CH][NPIX];
    logic [DW-1:0] fl [CH*NPIX];
    logic [DW-1:0] l1_keep [CH][NPIX];
    logic [DW-1:0] mem0_s [CH_S][IMG_S*IMG_S];
    logic [DW-1:0] l1_s [CH_S][NPIX_S];
    logic [DW-1:0] fl_s [CH_S*NPIX_S];
    int  fl_wr, l1_wr, bad_sel, quiet_wr, max_rd, fl_wr_s, l1_wr_s, bad_sel_s, viol;
    logic [15:0] rd_mask_s, wr_mask_s;
    bit  clr_req = 1'b0, quiet_watch = 1'b0;

    // Behavioural layer memories and bus logging for both instances.
    always @(posedge clk) begin
        if (clr_req) begin
            for (int c = 0; c < CH; c++) for (int i = 0; i < NPIX; i++) l1[c][i] <= 'x;
            for (int i = 0; i < CH*NPIX; i++) fl[i] <= 'x;
            for (int c = 0; c < CH_S; c++) for (int i = 0; i < NPIX_S; i++) l1_s[c][i] <= 'x;
            for (int i = 0; i < CH_S*NPIX_S; i++) fl_s[i] <= 'x;
            fl_wr <= 0; l1_wr <= 0; bad_sel <= 0; quiet_wr <= 0; max_rd <= 0;
            fl_wr_s <= 0; l1_wr_s <= 0; bad_sel_s <= 0; rd_mask_s <= '0; wr_mask_s <= '0;
        end else begin
            if (bus.crd) begin
                if (bus.csel >= 1 && int'(bus.csel) <= CH)
                    bus.cdata_rd <= mem0[int'(bus.csel) - 1][bus.caddr_rd];
                else
                    bad_sel <= bad_sel + 1;
                if (int'(bus.caddr_rd) > max_rd) max_rd <= int'(bus.caddr_rd);
            end
            if (bus.cwr) begin
                if (quiet_watch) quiet_wr <= quiet_wr + 1;
                if (int'(bus.csel) > CH && int'(bus.csel) <= 2*CH && int'(bus.caddr_wr) < NPIX) begin
                    l1[int'(bus.csel) - CH - 1][bus.caddr_wr] <= bus.cdata_wr;
                    l1_wr <= l1_wr + 1;
                end else if (int'(bus.csel) == 2*CH + 1 && int'(bus.caddr_wr) < CH*NPIX) begin
                    fl[bus.caddr_wr] <= bus.cdata_wr;
                    fl_wr <= fl_wr + 1;
                end else
                    bad_sel <= bad_sel + 1;
            end
            if (bus_s.crd) begin
                rd_mask_s <= rd_mask_s | (16'd1 << bus_s.csel);
                if (bus_s.csel >= 1 && int'(bus_s.csel) <= CH_S)
                    bus_s.cdata_rd <= mem0_s[int'(bus_s.csel) - 1][bus_s.caddr_rd];
                else
                    bad_sel_s <= bad_sel_s + 1;
            end
            if (bus_s.cwr) begin
                wr_mask_s <= wr_mask_s | (16'd1 << bus_s.csel);
                if (int'(bus_s.csel) > CH_S && int'(bus_s.csel) <= 2*CH_S && int'(bus_s.caddr_wr) < NPIX_S) begin
                    l1_s[int'(bus_s.csel) - CH_S - 1][bus_s.caddr_wr] <= bus_s.cdata_wr;
                    l1_wr_s <= l1_wr_s + 1;
                end else if (int'(bus_s.csel) == 2*CH_S + 1) begin
                    fl_s[bus_s.caddr_wr] <= bus_s.cdata_wr;
                    fl_wr_s <= fl_wr_s + 1;
                end else
                    bad_sel_s <= bad_sel_s + 1;
            end
        end
    end

    // Strobes never overlap, and an idle bus carries all-zero select/address/data.
    initial viol = 0;
    always @(negedge clk) begin
        if ((bus.crd && bus.cwr) || (!bus.crd && !bus.cwr &&
            (bus.csel != 0 || bus.caddr_rd != 0 || bus.caddr_wr != 0 || bus.cdata_wr != 0)))
            viol <= viol + 1;
        if ((bus_s.crd && bus_s.cwr) || (!bus_s.crd && !bus_s.cwr &&
            (bus_s.csel != 0 || bus_s.caddr_rd != 0 || bus_s.caddr_wr != 0 || bus_s.cdata_wr != 0)))
            viol <= viol + 1;
    end

    function automatic logic [DW-1:0] pool4(input logic [DW-1:0] a, b, c, d, input bit avg);
        int v [4];
        int s;
        v[0] = int'($signed(a)); v[1] = int'($signed(b));
        v[2] = int'($signed(c)); v[3] = int'($signed(d));
        if (avg) begin
            s = (v[0] + v[1] + v[2] + v[3]) >>> 2;
        end else begin
            s = v[0];
            for (int i = 1; i < 4; i++) if (v[i] > s) s = v[i];
        end
        return s[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] ref_big(input int ch, input int p, input bit avg);
        int b;
        b = 2 * (p / (IMG_W/2)) * IMG_W + 2 * (p % (IMG_W/2));
        return pool4(mem0[ch][b], mem0[ch][b+1], mem0[ch][b+IMG_W], mem0[ch][b+IMG_W+1], avg);
    endfunction

    function automatic logic [DW-1:0] ref_small(input int ch, input int p, input bit avg);
        int b;
        b = 2 * (p / (IMG_S/2)) * IMG_S + 2 * (p % (IMG_S/2));
        return pool4(mem0_s[ch][b], mem0_s[ch][b+1], mem0_s[ch][b+IMG_S], mem0_s[ch][b+IMG_S+1], avg);
    endfunction

    // Counts layer-1 (and optionally flatten) entries that differ from the reference.
    function automatic int big_errors(input bit avg, input bit with_fl, output int first);
        int n = 0;
        first = -1;
        for (int c = 0; c < CH; c++)
            for (int p = 0; p < NPIX; p++) begin
                if (l1[c][p] !== ref_big(c, p, avg) ||
                    (with_fl && fl[p*CH + c] !== ref_big(c, p, avg))) begin
                    if (first < 0) first = c * NPIX + p;
                    n++;
                end
            end
        return n;
    endfunction

    task automatic clear_logs;
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
    endtask

    // Starts a run, pulses ready with the opposite mode mid-run, and counts busy cycles.
    task automatic run_big(input bit mode, input bit fe, output int cycles);
        @(negedge clk);
        pool_mode = mode; flat_en = fe; ready = 1'b1;
        @(negedge clk);
        ready = 1'b0; pool_mode = ~mode; flat_en = ~fe;
        cycles = 0;
        while (busy && cycles < 20000) begin
            cycles++;
            if (cycles == 100) ready = 1'b1;
            if (cycles == 101) ready = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic load_ramp;
        for (int a = 0; a < IMG_W*IMG_W; a++) begin
            mem0[0][a] = DW'(a);
            mem0[1][a] = ~DW'(a);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        total++;
        if ({busy, bus.crd, bus.cwr, bus.csel, bus.caddr_rd, bus.caddr_wr, bus.cdata_wr} !== '0) begin
            bad++; $display("FAIL reset_outputs got busy=%b crd=%b cwr=%b csel=%h want all 0", busy, bus.crd, bus.cwr, bus.csel);
        end
        total++;
        if ({busy_s, bus_s.crd, bus_s.cwr, bus_s.csel} !== '0) begin
            bad++; $display("FAIL reset_outputs_small got busy=%b csel=%h want 0", busy_s, bus_s.csel);
        end
        rst_n = 1'b1;
        clear_logs();
    endtask

    task automatic test_max_flatten;
        int cyc, first, n;
        load_ramp();
        // Channel 1, pixel 1 window set to the most negative word.
        mem0[1][2] = 20'h80000; mem0[1][3] = 20'h80000; mem0[1][66] = 20'h80000; mem0[1][67] = 20'h80000;
        clear_logs();
        run_big(1'b0, 1'b1, cyc);
        total++; if (cyc !== 14337) begin bad++; $display("FAIL max_busy_len got=%0d want=14337", cyc); end
        total++; if (fl_wr !== 2048) begin bad++; $display("FAIL max_fl_writes got=%0d want=2048", fl_wr); end
        total++; if (l1[0][0] !== 20'h00041) begin bad++; $display("FAIL max_l1_0_0 got=%h want=00041", l1[0][0]); end
        total++; if (l1[1][0] !== 20'hFFFFF) begin bad++; $display("FAIL max_l1_1_0 got=%h want=fffff", l1[1][0]); end
        total++; if (fl[0] !== 20'h00041 || fl[1] !== 20'hFFFFF) begin
            bad++; $display("FAIL max_fl_0_1 got=%h,%h want=00041,fffff", fl[0], fl[1]); end
        total++; if (l1[1][1] !== 20'h80000) begin bad++; $display("FAIL max_min_value got=%h want=80000", l1[1][1]); end
        total++; if (l1[0][1023] !== 20'h00FFF) begin bad++; $display("FAIL max_last_pixel got=%h want=00fff", l1[0][1023]); end
        total++; if (fl[2047] !== 20'hFF041) begin bad++; $display("FAIL max_last_flat got=%h want=ff041", fl[2047]); end
        total++; if (max_rd !== 4095) begin bad++; $display("FAIL max_read_addr got=%0d want=4095", max_rd); end
        n = big_errors(1'b0, 1'b1, first);
        total++; if (n !== 0) begin bad++; $display("FAIL max_full_map got=%0d bad entries (first %0d) want=0", n, first); end
        for (int c = 0; c < CH; c++) for (int p = 0; p < NPIX; p++) l1_keep[c][p] = l1[c][p];
    endtask

    task automatic test_no_flatten;
        int cyc, n;
        clear_logs();
        run_big(1'b0, 1'b0, cyc);
        total++; if (cyc !== 12289) begin bad++; $display("FAIL nofl_busy_len got=%0d want=12289", cyc); end
        total++; if (fl_wr !== 0) begin bad++; $display("FAIL nofl_fl_writes got=%0d want=0", fl_wr); end
        total++; if (l1_wr !== 2048) begin bad++; $display("FAIL nofl_l1_writes got=%0d want=2048", l1_wr); end
        n = 0;
        for (int c = 0; c < CH; c++) for (int p = 0; p < NPIX; p++) if (l1[c][p] !== l1_keep[c][p]) n++;
        total++; if (n !== 0) begin bad++; $display("FAIL nofl_l1_same got=%0d differing want=0", n); end
    endtask

    task automatic test_reset_mid_run;
        clear_logs();
        @(negedge clk);
        pool_mode = 1'b0; flat_en = 1'b1; ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        repeat (499) @(negedge clk);
        total++; if (fl_wr !== 71) begin bad++; $display("FAIL rst_partial_writes got=%0d want=71", fl_wr); end
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, bus.crd, bus.cwr, bus.csel, bus.caddr_rd, bus.caddr_wr, bus.cdata_wr} !== '0) begin
            bad++; $display("FAIL rst_mid_outputs got busy=%b crd=%b csel=%h addr=%h want all 0", busy, bus.crd, bus.csel, bus.caddr_rd);
        end
        quiet_watch = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        quiet_watch = 1'b0;
        total++; if (quiet_wr !== 0 || busy !== 1'b0) begin
            bad++; $display("FAIL rst_quiet got cwr=%0d busy=%b want 0,0", quiet_wr, busy); end
    endtask

    task automatic test_average;
        int cyc, first, n;
        load_ramp();
        mem0[0][0] = DW'(7);  mem0[0][1] = DW'(8);  mem0[0][64] = -DW'(3); mem0[0][65] = -DW'(5);
        mem0[1][0] = -DW'(1); mem0[1][1] = -DW'(1); mem0[1][64] = -DW'(1); mem0[1][65] = -DW'(2);
        mem0[0][2] = 20'h80000; mem0[0][3] = 20'h80000; mem0[0][66] = 20'h80000; mem0[0][67] = 20'h80000;
        clear_logs();
        run_big(1'b1, 1'b1, cyc);
        total++; if (cyc !== 14337) begin bad++; $display("FAIL avg_busy_len got=%0d want=14337", cyc); end
        total++; if (l1[0][0] !== 20'h00001) begin bad++; $display("FAIL avg_pos got=%h want=00001", l1[0][0]); end
        total++; if (l1[1][0] !== 20'hFFFFE) begin bad++; $display("FAIL avg_floor got=%h want=ffffe", l1[1][0]); end
        total++; if (l1[0][1] !== 20'h80000) begin bad++; $display("FAIL avg_min_value got=%h want=80000", l1[0][1]); end
        total++; if (fl[0] !== 20'h00001 || fl[1] !== 20'hFFFFE || fl[2] !== 20'h80000) begin
            bad++; $display("FAIL avg_flat got=%h,%h,%h want=00001,ffffe,80000", fl[0], fl[1], fl[2]); end
        n = big_errors(1'b1, 1'b1, first);
        total++; if (n !== 0) begin bad++; $display("FAIL avg_full_map got=%0d bad entries (first %0d) want=0", n, first); end
        total++; if (viol !== 0 || bad_sel !== 0) begin
            bad++; $display("FAIL bus_rule got viol=%0d bad_sel=%0d want 0,0", viol, bad_sel); end
    endtask

    task automatic test_small_config;
        int cyc, n, m;
        for (int c = 0; c < CH_S; c++)
            for (int a = 0; a < IMG_S*IMG_S; a++) mem0_s[c][a] = DW'(((a * 37 + c * 11) % 97) - 48);
        mem0_s[3][54] = 20'h80000; mem0_s[3][55] = 20'h80000; mem0_s[3][62] = 20'h80000; mem0_s[3][63] = 20'h80000;
        clear_logs();
        @(negedge clk);
        mode_s = 1'b0; flat_s = 1'b1; ready_s = 1'b1;
        @(negedge clk);
        ready_s = 1'b0;
        cyc = 0;
        while (busy_s && cyc < 2000) begin cyc++; @(negedge clk); end
        total++; if (cyc !== 449) begin bad++; $display("FAIL small_busy_len got=%0d want=449", cyc); end
        total++; if (rd_mask_s !== 16'h001E) begin bad++; $display("FAIL small_read_csel got=%h want=001e", rd_mask_s); end
        total++; if (wr_mask_s !== 16'h03E0) begin bad++; $display("FAIL small_write_csel got=%h want=03e0", wr_mask_s); end
        total++; if (fl_wr_s !== 64 || l1_wr_s !== 64 || bad_sel_s !== 0) begin
            bad++; $display("FAIL small_write_counts got fl=%0d l1=%0d bad=%0d want 64,64,0", fl_wr_s, l1_wr_s, bad_sel_s); end
        total++; if (l1_s[3][15] !== 20'h80000) begin bad++; $display("FAIL small_min_last got=%h want=80000", l1_s[3][15]); end
        n = 0; m = 0;
        for (int c = 0; c < CH_S; c++)
            for (int p = 0; p < NPIX_S; p++) begin
                if (fl_s[p*CH_S + c] !== l1_s[c][p]) n++;
                if (l1_s[c][p] !== ref_small(c, p, 1'b0)) m++;
            end
        total++; if (n !== 0) begin bad++; $display("FAIL small_flat_vs_l1 got=%0d differing want=0", n); end
        total++; if (m !== 0) begin bad++; $display("FAIL small_l1_model got=%0d differing want=0", m); end
    endtask

    initial begin
        test_reset();
        test_max_flatten();
        test_no_flatten();
        test_reset_mid_run();
        test_average();
        test_small_config();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
